// File: rtl/prbs_xnor_checker_pkg.sv
// Shared types and helpers for the XNOR-feedback PRBS receive checker.
package prbs_xnor_checker_pkg;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int unsigned PRBS7_WIDTH = 7;
    localparam int unsigned PRBS7_TAP_A = 7;
    localparam int unsigned PRBS7_TAP_B = 6;
    localparam int unsigned MAX_WIDTH   = 64;

    // Taps are 1-based, matching polynomial exponents.
    function automatic logic xnor_fb(input logic [MAX_WIDTH-1:0] lfsr,
                                     input int unsigned ta,
                                     input int unsigned tb);
        logic [MAX_WIDTH-1:0] sa;
        logic [MAX_WIDTH-1:0] sb;
        sa = lfsr >> (ta - 1);
        sb = lfsr >> (tb - 1);
        return ~(sa[0] ^ sb[0]);
    endfunction

endpackage

// File: rtl/prbs_xnor_checker_lfsr.sv
// Local XNOR LFSR: shifts either the received bit or its own prediction.
module prbs_xnor_lfsr
    import prbs_xnor_checker_pkg::*;
#(
    parameter int unsigned WIDTH = PRBS7_WIDTH,
    parameter int unsigned TAP_A = PRBS7_TAP_A,
    parameter int unsigned TAP_B = PRBS7_TAP_B
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic use_din,
    input  logic load_bit,
    output logic pred,
    output logic seed_ones
);

    logic [WIDTH-1:0] lfsr;

    assign pred = xnor_fb(MAX_WIDTH'(lfsr), TAP_A, TAP_B);

    // All-ones is the XNOR lock-up state; flag it before load_bit is shifted in.
    assign seed_ones = &{lfsr[WIDTH-2:0], load_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= '0;
        end else if (shift_en) begin
            lfsr <= {lfsr[WIDTH-2:0], use_din ? load_bit : pred};
        end
    end

endmodule

// File: rtl/prbs_xnor_checker.sv
// XNOR PRBS checker: self-synchronises to the incoming stream, tracks lock and counts bit errors.
module prbs_xnor_checker
    import prbs_xnor_checker_pkg::*;
#(
    parameter int unsigned WIDTH       = PRBS7_WIDTH,
    parameter int unsigned TAP_A       = PRBS7_TAP_A,
    parameter int unsigned TAP_B       = PRBS7_TAP_B,
    parameter int unsigned LOCK_COUNT  = 16,
    parameter int unsigned LOSS_ERRORS = 4,
    parameter int unsigned LOSS_WINDOW = 64,
    parameter int unsigned ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din_valid,
    input  logic                 din,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned CNT_MAX = (WIDTH > LOCK_COUNT) ? WIDTH : LOCK_COUNT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned WIN_W   = $clog2(LOSS_WINDOW + 1);
    localparam int unsigned WERR_W  = $clog2(LOSS_ERRORS + 1);

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [WERR_W-1:0] win_err;
    logic [WERR_W-1:0] win_err_next;
    logic              pred;
    logic              seed_ones;
    logic              mismatch;

    prbs_xnor_lfsr #(
        .WIDTH (WIDTH),
        .TAP_A (TAP_A),
        .TAP_B (TAP_B)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (din_valid),
        .use_din   (state != LOCKED),
        .load_bit  (din),
        .pred      (pred),
        .seed_ones (seed_ones)
    );

    assign mismatch     = din ^ pred;
    assign win_err_next = win_err + WERR_W'(mismatch);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEED;
            bit_cnt   <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (din_valid) begin
                case (state)
                    SEED: begin
                        if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                            bit_cnt <= '0;
                            if (!seed_ones) state <= HUNT;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    HUNT: begin
                        if (mismatch) begin
                            state   <= SEED;
                            bit_cnt <= '0;
                        end else if (bit_cnt == CNT_W'(LOCK_COUNT - 1)) begin
                            state   <= LOCKED;
                            bit_cnt <= '0;
                            locked  <= 1'b1;
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    LOCKED: begin
                        err_pulse <= mismatch;
                        // Loss is checked before the window wrap so an error on the last bit still counts.
                        if (win_err_next == WERR_W'(LOSS_ERRORS)) begin
                            state   <= SEED;
                            locked  <= 1'b0;
                            win_cnt <= '0;
                            win_err <= '0;
                        end else if (win_cnt == WIN_W'(LOSS_WINDOW - 1)) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                            win_err <= win_err_next;
                        end
                    end
                    default: begin
                        state   <= SEED;
                        bit_cnt <= '0;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (clear) begin
            err_count <= '0;
        end else if (din_valid && state == LOCKED && mismatch && !(&err_count)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_prbs_xnor_checker.sv
// Scoreboard bench for prbs_xnor_checker: a wide-counter and a 4-bit-counter instance share one stimulus stream.
module tb_prbs_xnor_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din_valid = 1'b0;
    logic        din = 1'b0;
    logic        clear = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic        locked4, err_pulse4;
    logic [3:0]  err_count4;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic        locked;
        logic        pulse;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t        sb[$];
    logic [6:0]  gen = '0;
    logic        exp_locked = 1'b0;
    logic [15:0] exp_cnt = '0;
    logic [3:0]  exp_cnt4 = '0;

    always #5 clk = ~clk;

    prbs_xnor_checker #(
        .WIDTH       (7),
        .TAP_A       (7),
        .TAP_B       (6),
        .LOCK_COUNT  (16),
        .LOSS_ERRORS (4),
        .LOSS_WINDOW (64),
        .ERR_CNT_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    prbs_xnor_checker #(
        .ERR_CNT_W (4)
    ) dut4 (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .clear     (clear),
        .locked    (locked4),
        .err_pulse (err_pulse4),
        .err_count (err_count4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bump_err();
        exp_cnt = exp_cnt + 16'd1;
        if (exp_cnt4 != 4'hF) exp_cnt4 = exp_cnt4 + 4'd1;
    endtask

    // mode: 0 clean stream bit, 1 inverted stream bit, 2 constant one (stream not advanced)
    task automatic step(input logic v, input int mode, input logic clr, input logic pulse, input string tag);
        exp_t e;
        logic b;
        din_valid = v;
        clear     = clr;
        if (!v) begin
            din = 1'($urandom_range(0, 1));
        end else if (mode == 2) begin
            din = 1'b1;
        end else begin
            b   = ~(gen[6] ^ gen[5]);
            gen = {gen[5:0], b};
            din = (mode == 1) ? ~b : b;
        end
        e.tag    = tag;
        e.locked = exp_locked;
        e.pulse  = pulse;
        e.cnt    = exp_cnt;
        e.cnt4   = exp_cnt4;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, "/locked"},    32'(locked),     32'(e.locked));
        check({e.tag, "/err_pulse"}, 32'(err_pulse),  32'(e.pulse));
        check({e.tag, "/err_count"}, 32'(err_count),  32'(e.cnt));
        check({e.tag, "/locked4"},   32'(locked4),    32'(e.locked));
        check({e.tag, "/err_cnt4"},  32'(err_count4), 32'(e.cnt4));
        din_valid = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        exp_locked = 1'b0;
        exp_cnt    = '0;
        exp_cnt4   = '0;
    endtask

    initial begin
        #2;
        check("reset/locked",    32'(locked),     32'h0);
        check("reset/err_pulse", 32'(err_pulse),  32'h0);
        check("reset/err_count", 32'(err_count),  32'h0);
        check("reset/err_cnt4",  32'(err_count4), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 1; i <= 23; i++) begin
            exp_locked = (i == 23);
            step(1'b1, 0, 1'b0, 1'b0, "acquire");
        end
        repeat (5) step(1'b1, 0, 1'b0, 1'b0, "locked_run");

        bump_err();
        step(1'b1, 1, 1'b0, 1'b1, "single_err");
        repeat (4) step(1'b1, 0, 1'b0, 1'b0, "after_err");

        // Asynchronous reset between edges while locked with a nonzero count.
        #3;
        rst = 1'b1;
        #1;
        check("async/locked",    32'(locked),     32'h0);
        check("async/err_count", 32'(err_count),  32'h0);
        check("async/err_cnt4",  32'(err_count4), 32'h0);
        rst        = 1'b0;
        exp_locked = 1'b0;
        exp_cnt    = '0;
        exp_cnt4   = '0;

        for (int i = 1; i <= 23; i++) begin
            exp_locked = (i == 23);
            step(1'b1, 0, 1'b0, 1'b0, "acquire2");
        end
        for (int k = 1; k <= 4; k++) begin
            repeat (3) step(1'b1, 0, 1'b0, 1'b0, "loss_gap");
            bump_err();
            if (k == 4) exp_locked = 1'b0;
            step(1'b1, 1, 1'b0, 1'b1, "loss_err");
        end
        for (int i = 1; i <= 23; i++) begin
            exp_locked = (i == 23);
            step(1'b1, 0, 1'b0, 1'b0, "relock");
        end

        reset_dut();
        repeat (200) step(1'b1, 2, 1'b0, 1'b0, "lockup");

        reset_dut();
        for (int i = 1; i <= 23; i++) begin
            exp_locked = (i == 23);
            step(1'b1, 0, 1'b0, 1'b0, "gap_valid");
            step(1'b0, 0, 1'b0, 1'b0, "gap_idle");
        end

        for (int k = 1; k <= 20; k++) begin
            repeat (31) step(1'b1, 0, 1'b0, 1'b0, "sat_clean");
            bump_err();
            step(1'b1, 1, 1'b0, 1'b1, "sat_err");
        end

        repeat (5) step(1'b1, 0, 1'b0, 1'b0, "pre_clear");
        exp_cnt  = '0;
        exp_cnt4 = '0;
        step(1'b1, 1, 1'b1, 1'b1, "clear_with_err");
        repeat (5) step(1'b1, 0, 1'b0, 1'b0, "post_clear");
        bump_err();
        step(1'b1, 1, 1'b0, 1'b1, "err_after_clear");
        exp_cnt  = '0;
        exp_cnt4 = '0;
        step(1'b1, 0, 1'b1, 1'b0, "plain_clear");
        repeat (2) step(1'b1, 0, 1'b0, 1'b0, "tail");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
